// File: rtl/tt_um_rejunity_1_58bit.sv
// Ternary-weight (1.58-bit) matrix-vector multiplier, Tiny Tapeout user top.
// Computes y[j] += w[j]*x for CH = 3*COMPUTE_SLICES channels, one column per MAC.
// Ports: clk, rst_n (async active-low), ena (0 = NOP),
//   ui_in  [7:6] opcode / [5:0] operand,
//   uio_in signed activation x (MAC only),
//   uo_out registered readout byte,
//   uio_out / uio_oe tied to 0 (all bidirectional pins are inputs).
// Opcodes: 00 NOP/CLEAR, 01 LOADW, 10 MAC, 11 READ.
// Build option: define SATURATE_EN to clamp accumulators to
//   +32767 / -32768 instead of 16-bit wrap-around.
module tt_um_rejunity_1_58bit #(
    parameter int COMPUTE_SLICES = 4
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int CH = 3 * COMPUTE_SLICES;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_LOADW = 2'b01,
        OP_MAC   = 2'b10,
        OP_READ  = 2'b11
    } op_t;

    op_t                op;
    logic        [4:0]  rd_index;
    logic               rd_hi;
    logic        [7:0]  rd_byte;
    logic signed [7:0]  x;

    logic        [1:0]  w        [CH];
    logic signed [15:0] acc      [CH];
    logic signed [15:0] acc_next [CH];

    assign op       = op_t'(ui_in[7:6]);
    assign rd_index = ui_in[5:1];
    assign rd_hi    = ui_in[0];
    assign x        = uio_in;
    assign uio_out  = 8'h00;
    assign uio_oe   = 8'h00;

    // One accumulate step. The 17-bit sum keeps the true result so the
    // saturating build can detect overflow from the top two bits.
    function automatic logic signed [15:0] mac_step(
        input logic signed [15:0] a,
        input logic        [1:0]  t,
        input logic signed [7:0]  v
    );
        logic signed [16:0] s;
        logic signed [16:0] ve;
        ve = {{9{v[7]}}, v};
        case (t)
            2'b01:   s = {a[15], a} + ve;
            2'b11:   s = {a[15], a} - ve;
            default: s = {a[15], a};
        endcase
`ifdef SATURATE_EN
        if (s[16] != s[15]) begin
            return s[16] ? 16'sh8000 : 16'sh7FFF;
        end
`endif
        return s[15:0];
    endfunction

    always_comb begin
        for (int j = 0; j < CH; j++) begin
            acc_next[j] = mac_step(acc[j], w[j], x);
        end
    end

    // Out-of-range indices fall through and read as zero.
    always_comb begin
        rd_byte = 8'h00;
        for (int j = 0; j < CH; j++) begin
            if (rd_index == 5'(j)) begin
                rd_byte = rd_hi ? acc[j][15:8] : acc[j][7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < CH; j++) begin
                w[j]   <= 2'b00;
                acc[j] <= 16'sd0;
            end
            uo_out <= 8'h00;
        end else if (ena) begin
            case (op)
                OP_NOP: begin
                    if (ui_in[5]) begin
                        for (int j = 0; j < CH; j++) begin
                            acc[j] <= 16'sd0;
                        end
                    end
                end
                OP_LOADW: begin
                    // Shift whole slices up; slice 0 takes the new trits.
                    w[0] <= ui_in[1:0];
                    w[1] <= ui_in[3:2];
                    w[2] <= ui_in[5:4];
                    for (int j = 3; j < CH; j++) begin
                        w[j] <= w[j-3];
                    end
                end
                OP_MAC: begin
                    for (int j = 0; j < CH; j++) begin
                        acc[j] <= acc_next[j];
                    end
                end
                default: begin
                    uo_out <= rd_byte;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_um_rejunity_1_58bit.sv
// Directed self-checking bench for tt_um_rejunity_1_58bit.
// Expected bytes are hand-computed for COMPUTE_SLICES = 4.
module tb_tt_um_rejunity_1_58bit;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int tests;
    int fails;

    tt_um_rejunity_1_58bit #(.COMPUTE_SLICES(4)) dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [7:0] ui, input logic [7:0] x,
                        input logic en);
        @(negedge clk);
        ui_in  = ui;
        uio_in = x;
        ena    = en;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] idx,
                      input logic b, input logic [7:0] exp);
        step({2'b11, idx, b}, 8'h00, 1'b1);
        check(tag, uo_out, exp);
    endtask

    task automatic mac(input logic [7:0] x);
        step(8'h80, x, 1'b1);
    endtask

    task automatic clear();
        step(8'h20, 8'h00, 1'b1);
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        check("rst_uo", uo_out, 8'h00);
        check("uio_oe", uio_oe, 8'h00);
        check("uio_out", uio_out, 8'h00);
        rd("rst_j0_b0", 5'd0, 1'b0, 8'h00);
        rd("rst_j0_b1", 5'd0, 1'b1, 8'h00);

        // slices all (+1, 0, -1)
        repeat (4) step(8'h71, 8'h00, 1'b1);
        mac(8'd5);
        rd("x5_j0", 5'd0, 1'b0, 8'h05);
        rd("x5_j1", 5'd1, 1'b0, 8'h00);
        rd("x5_j2_lo", 5'd2, 1'b0, 8'hFB);
        rd("x5_j2_hi", 5'd2, 1'b1, 8'hFF);
        rd("x5_j11", 5'd11, 1'b0, 8'hFB);

        clear();
        repeat (3) mac(8'h80);
        rd("n384_lo", 5'd0, 1'b0, 8'h80);
        rd("n384_hi", 5'd0, 1'b1, 8'hFE);
        rd("p384_lo", 5'd2, 1'b0, 8'h80);
        rd("p384_hi", 5'd2, 1'b1, 8'h01);

        clear();
        rd("clr_j0", 5'd0, 1'b0, 8'h00);
        mac(8'd1);
        rd("keepw_j0", 5'd0, 1'b0, 8'h01);
        rd("keepw_j2", 5'd2, 1'b1, 8'hFF);

        step(8'h80, 8'd50, 1'b0);
        rd("ena0_mac", 5'd0, 1'b0, 8'h01);
        step(8'hC5, 8'h00, 1'b0);
        check("ena0_read", uo_out, 8'h01);

        rd("idx31_lo", 5'd31, 1'b0, 8'h00);
        rd("idx12_hi", 5'd12, 1'b1, 8'h00);

        clear();
        repeat (259) mac(8'd127);
`ifdef SATURATE_EN
        rd("wrap_j0_lo", 5'd0, 1'b0, 8'hFF);
        rd("wrap_j0_hi", 5'd0, 1'b1, 8'h7F);
        rd("wrap_j2_lo", 5'd2, 1'b0, 8'h00);
        rd("wrap_j2_hi", 5'd2, 1'b1, 8'h80);
`else
        rd("wrap_j0_lo", 5'd0, 1'b0, 8'h7D);
        rd("wrap_j0_hi", 5'd0, 1'b1, 8'h80);
        rd("wrap_j2_lo", 5'd2, 1'b0, 8'h83);
        rd("wrap_j2_hi", 5'd2, 1'b1, 8'h7F);
`endif

        // one shift: slice0 = (0,+1,0), slices 1..3 = (+1,0,-1)
        step(8'h44, 8'h00, 1'b1);
        clear();
        mac(8'd3);
        rd("shift_j0", 5'd0, 1'b0, 8'h00);
        rd("shift_j1", 5'd1, 1'b0, 8'h03);
        rd("shift_j5", 5'd5, 1'b0, 8'hFD);
        rd("shift_j9", 5'd9, 1'b0, 8'h03);

        // asynchronous reset between edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_uo", uo_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        rd("arst_j1", 5'd1, 1'b0, 8'h00);
        rd("arst_j5", 5'd5, 1'b0, 8'h00);
        mac(8'd9);
        rd("arst_w_j9", 5'd9, 1'b0, 8'h00);
        rd("arst_w_j1", 5'd1, 1'b0, 8'h00);
        check("uio_oe_end", uio_oe, 8'h00);
        check("uio_out_end", uio_out, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
